// File: rtl/load_unit.sv
// Single-outstanding load unit: captures a request, issues one word read,
// then returns an aligned, sign/zero-extended result or an error response.
module load_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  load_option,
  output logic        mem_rd_en,
  output logic [10:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; once raised, resp_valid and its payload hold until accepted.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [12:0]   addr_q;
  logic [2:0]    opt_q;
  logic [CW-1:0] cnt;
  logic          bad_req;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign req_ready  = (state == IDLE);
  assign mem_rd_en  = (state == READ);
  assign resp_valid = (state == RESP);
  assign mem_addr   = addr_q[12:2];
  assign dbg_state  = state;

  // Rejected before any memory access: unknown option or misaligned lh/lhu/lw.
  always_comb begin
    bad_req = 1'b0;
    case (load_option)
      3'b000:         bad_req = (req_addr[1:0] != 2'b00);
      3'b010, 3'b110: bad_req = req_addr[0];
      3'b001, 3'b101: bad_req = 1'b0;
      default:        bad_req = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = mem_rdata[7:0];
      2'b01: byte_sel = mem_rdata[15:8];
      2'b10: byte_sel = mem_rdata[23:16];
      2'b11: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = 32'd0;
    case (opt_q)
      3'b000: load_val = mem_rdata;
      3'b001: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b101: load_val = {24'd0, byte_sel};
      3'b010: load_val = {{16{half_sel[15]}}, half_sel};
      3'b110: load_val = {16'd0, half_sel};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_valid) state_n = bad_req ? RESP : READ;
      READ: state_n = WAIT;
      WAIT: if (mem_rd_valid || cnt == CNT_MAX) state_n = RESP;
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      opt_q     <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr[12:0];
            opt_q  <= load_option;
            if (bad_req) begin
              resp_data <= '0;
              resp_err  <= 1'b1;
            end
          end
        end
        READ: cnt <= '0;
        WAIT: begin
          // Data arriving on the final counted cycle still wins over timeout.
          if (mem_rd_valid) begin
            resp_data <= load_val;
            resp_err  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a driver issues loads and pushes expected
// responses; an independent monitor pops and compares on each handshake.
module tb_load_unit;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  load_option = '0;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [1:0]  dbg_state;

  load_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .load_option(load_option),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  int stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // consumer: optionally stalls resp_ready while a response is pending
  always @(negedge clock) begin
    if (resp_valid && stall_left > 0) begin
      resp_ready = 1'b0;
      stall_left--;
      check("stall_req_ready", req_ready, 0);
    end else begin
      resp_ready = 1'b1;
    end
  end

  // scoreboard monitor
  logic        in_resp = 1'b0;
  logic [32:0] held = '0;
  always @(negedge clock) begin
    #1;
    if (reset) begin
      in_resp = 1'b0;
    end else if (resp_valid) begin
      if (in_resp) check("resp_stable", {resp_err, resp_data}, held);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got %0h expected none", {resp_err, resp_data});
      end else if (resp_ready) begin
        check("resp", {resp_err, resp_data}, exp_q.pop_front());
        in_resp = 1'b0;
      end else begin
        in_resp = 1'b1;
        held    = {resp_err, resp_data};
      end
    end else begin
      in_resp = 1'b0;
    end
  end

  // driver tasks
  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 60) begin
      @(negedge clock);
      k++;
    end
    if (k == 60) check("req_ready_timeout", req_ready, 1);
  endtask

  task automatic wait_drained();
    int k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      @(negedge clock);
      k++;
    end
    if (k == 80) check("drain_timeout", exp_q.size(), 0);
  endtask

  // delay < 0: memory never answers
  task automatic do_load(input logic [31:0] addr, input logic [2:0] opt,
                         input logic [31:0] rdata, input int delay,
                         input logic exp_err, input logic [31:0] exp_data,
                         input bit check_lat);
    int t_acc;
    int k;
    exp_q.push_back({exp_err, exp_data});
    wait_ready();
    req_valid   = 1'b1;
    req_addr    = addr;
    load_option = opt;
    @(posedge clock);
    #1 t_acc = cyc;
    @(negedge clock);
    req_valid = 1'b0;
    if (!exp_err || delay < 0) begin
      check("mem_rd_en", mem_rd_en, 1);
      check("mem_addr", mem_addr, {53'd0, addr[12:2]});
      @(negedge clock);
      check("rd_en_one_cycle", mem_rd_en, 0);
      if (delay >= 0) begin
        repeat (delay) @(negedge clock);
        mem_rd_valid = 1'b1;
        mem_rdata    = rdata;
        @(negedge clock);
        mem_rd_valid = 1'b0;
        mem_rdata    = $urandom();
        if (check_lat) check("latency_t3", resp_valid, 1);
      end else begin
        k = 0;
        while (!resp_valid && k < 40) begin
          @(negedge clock);
          k++;
        end
        check("timeout_cycle", cyc - t_acc, TIMEOUT + 2);
      end
    end else begin
      check("no_rd_en", mem_rd_en, 0);
    end
    wait_drained();
  endtask

  initial begin
    // reset values
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp", {resp_err, resp_data}, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // byte / halfword / word extraction
    do_load(32'h0000_0103, 3'b001, 32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80, 1'b1);
    do_load(32'h0000_0002, 3'b110, 32'h9ABC_5678, 0, 1'b0, 32'h0000_9ABC, 1'b1);
    do_load(32'h0000_0002, 3'b010, 32'h9ABC_5678, 0, 1'b0, 32'hFFFF_9ABC, 1'b0);
    do_load(32'h0000_0101, 3'b101, 32'h80FF_1234, 1, 1'b0, 32'h0000_0012, 1'b0);
    do_load(32'h0000_0102, 3'b001, 32'h80FF_1234, 0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    do_load(32'h0000_0102, 3'b101, 32'h80FF_1234, 2, 1'b0, 32'h0000_00FF, 1'b0);
    do_load(32'h0000_0100, 3'b001, 32'h80FF_1234, 0, 1'b0, 32'h0000_0034, 1'b0);
    do_load(32'h0000_0000, 3'b010, 32'h0000_8001, 3, 1'b0, 32'hFFFF_8001, 1'b0);

    // rejected requests
    do_load(32'h0000_0006, 3'b000, 32'h0, 0, 1'b1, 32'h0, 1'b0);
    do_load(32'h0000_0000, 3'b011, 32'h0, 0, 1'b1, 32'h0, 1'b0);
    do_load(32'h0000_0001, 3'b010, 32'h0, 0, 1'b1, 32'h0, 1'b0);
    do_load(32'h0000_0004, 3'b111, 32'h0, 0, 1'b1, 32'h0, 1'b0);

    // data on the last counted WAIT cycle is still good data
    do_load(32'h0000_0010, 3'b000, 32'hDEAD_BEEF, TIMEOUT, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // timeout, then a stray late read-valid, then a normal load
    do_load(32'h0000_0000, 3'b000, 32'h0, -1, 1'b1, 32'h0, 1'b0);
    mem_rd_valid = 1'b1;
    mem_rdata    = 32'h5555_AAAA;
    @(negedge clock);
    mem_rd_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("late_valid_ignored", {resp_valid, req_ready}, 2'b01);
    end
    do_load(32'h0000_0020, 3'b000, 32'h1122_3344, 0, 1'b0, 32'h1122_3344, 1'b0);

    // response back-pressure, then immediate next request
    stall_left = 5;
    do_load(32'h0000_0024, 3'b000, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
    check("ready_after_hs", req_ready, 1);
    do_load(32'h0000_0025, 3'b101, 32'hCAFE_F00D, 0, 1'b0, 32'h0000_00F0, 1'b0);

    // asynchronous reset while waiting for memory
    wait_ready();
    req_valid   = 1'b1;
    req_addr    = 32'h0000_1FFC;
    load_option = 3'b000;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_state", dbg_state, 2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_mem_rd_en", mem_rd_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_resp", {resp_valid, resp_err, resp_data}, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rdata    = 32'h7777_7777;
    @(negedge clock);
    mem_rd_valid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("no_resp_after_rst", resp_valid, 0);
    end
    do_load(32'h0000_0008, 3'b000, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 1'b0);

    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) check("leftover_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: the maximum number of cycles spent waiting for memory read data before an error response.
REQ-002 clock  input  1  The single clock; all state updates on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 req_valid  input  1  A load request is present.
REQ-005 req_ready  output  1  The block accepts a request this cycle.
REQ-006 req_addr  input  32  Byte address of the load.
REQ-007 load_option  input  3  Load type: 000 lw, 001 lb, 010 lh, 101 lbu, 110 lhu; all other codes are illegal.
REQ-008 mem_rd_en  output  1  One-cycle read strobe to the word memory.
REQ-009 mem_addr  output  11  Word index, equal to the captured address bits [12:2].
REQ-010 mem_rd_valid  input  1  mem_rdata is valid this cycle.
REQ-011 mem_rdata  input  32  Word read from memory.
REQ-012 resp_valid  output  1  A response is present.
REQ-013 resp_ready  input  1  The consumer accepts the response.
REQ-014 resp_data  output  32  Aligned, extended load result.
REQ-015 resp_err  output  1  The response is an error (misaligned, illegal option, or timeout).

Function
REQ-016 The block SHALL implement the FSM states IDLE, READ, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1, and req_addr and load_option are captured on that cycle.
REQ-018 On acceptance, the block SHALL go IDLE->RESP with resp_err=1 and resp_data=0 if the option is illegal, if lh/lhu has addr[0]=1, or if lw has addr[1:0]!=00; no memory read is issued in that case.
REQ-019 Otherwise the block SHALL go IDLE->READ; in READ, mem_rd_en=1 for exactly one cycle with mem_addr=addr[12:2], then READ->WAIT.
REQ-020 In WAIT, on mem_rd_valid=1 the block SHALL latch the extracted result into resp_data, clear resp_err, and go WAIT->RESP.
REQ-021 Byte extraction SHALL select byte addr[1:0]: 00=[7:0], 01=[15:8], 10=[23:16], 11=[31:24]; lb sign-extends bit 7 of the byte, lbu zero-extends.
REQ-022 Halfword extraction SHALL use addr[1]=0 -> [15:0] and addr[1]=1 -> [31:16]; lh sign-extends, lhu zero-extends; lw passes all 32 bits.
REQ-023 A WAIT cycle counter SHALL start at 0 on entering WAIT; if it reaches TIMEOUT with no mem_rd_valid, the block goes WAIT->RESP with resp_err=1 and resp_data=0.
REQ-024 mem_rd_valid SHALL be ignored in any state other than WAIT, and a late mem_rd_valid after a timeout SHALL have no effect.
REQ-025 In RESP, resp_valid=1 and resp_data/resp_err SHALL hold stable until resp_ready=1; on that cycle the block goes RESP->IDLE.
REQ-026 Minimum latency: request accepted in cycle T, mem_rd_en in T+1, mem_rd_valid in T+2, resp_valid in T+3.
REQ-027 Back-to-back operation: req_ready SHALL return to 1 in the cycle after the response handshake, so one load is in flight at a time.
REQ-028 mem_rd_valid arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as valid data (no error).

Reset
REQ-029 Reset assertion SHALL immediately force state IDLE, with req_ready=1, mem_rd_en=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0, and the counter at 0.
REQ-030 A reset mid-operation SHALL abandon the in-flight load; no response is produced for it after reset releases.

Verification
REQ-031 lb at addr 0x0000_0103, mem_rdata=0x80FF_1234 -> mem_addr=0x040, resp_data=0xFFFF_FF80, resp_err=0, resp_valid at T+3.
REQ-032 lhu at 0x0000_0002, mem_rdata=0x9ABC_5678 -> resp_data=0x0000_9ABC; lh at the same address -> 0xFFFF_9ABC.
REQ-033 lw at 0x0000_0006 -> no mem_rd_en pulse, resp_err=1, resp_data=0; load_option=011 at 0x0000_0000 -> resp_err=1.
REQ-034 lw with mem_rd_valid held low for 20 cycles -> resp_err=1 after TIMEOUT cycles in WAIT; a later mem_rd_valid pulse is ignored and the next request is served normally.
REQ-035 resp_ready held low for 5 cycles -> resp_valid and resp_data stay stable and req_ready stays 0; a new request is accepted the cycle after the handshake.
REQ-036 reset pulsed during WAIT -> all outputs return to reset values immediately and no response follows.
